pll_reconfig_seq: RTL and testbench

Sequencer that reprograms the system PLL via the Altera PLL reconfiguration management bus when the selected video/clock mode changes. It generalises the fixed two-mode NTSC/PAL reconfiguration to `MODES` modes and up to `WRITES` register writes per mode, supplied through an external lookup table. It adds an explicit request input, lock confirmation with timeout, and queuing of mode changes that arrive mid-sequence. It runs in the `CLK_50M` domain, sits between the status/OSD logic and `pll_cfg`, and drives the core reset while the clock is unstable.

---
 rtl/pll_reconfig_seq.sv | 149 ++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: reprograms the system PLL over the reconfig bus when the selected mode changes
module pll_reconfig_seq #(
  parameter int MODES = 2,
  parameter int MODE_W = $clog2(MODES),
  parameter int WRITES = 4,
  parameter int LOCK_TIMEOUT = 65535,
  parameter bit INIT_CFG = 0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode,
  input  logic              start,
  output logic [MODE_W-1:0] tbl_mode,
  output logic [3:0]        tbl_idx,
  input  logic [5:0]        tbl_addr,
  input  logic [31:0]       tbl_data,
  input  logic              cfg_waitrequest,
  output logic              cfg_write,
  output logic [5:0]        cfg_address,
  output logic [31:0]       cfg_data,
  input  logic              pll_locked,
  output logic              core_reset,
  output logic              busy,
  output logic [MODE_W-1:0] cur_mode,
  output logic              lock_err
);
  localparam int CW = $clog2(LOCK_TIMEOUT + 17);
  typedef enum logic [2:0] {IDLE, PRE, TBL, GO, UNLOCK, LOCK, DONE} state_t;
  state_t state, state_n;
  logic [MODE_W-1:0] mode_s1, mode_s2, mode_s3, seq_mode, seq_mode_n, cur_mode_n;
  logic lock_s1, lock_s2, rst_d, trig, go_pre, wr_done, tbl_end;
  logic pending, pending_n, core_reset_n, lock_err_n, wr_n;
  logic [5:0] addr_n;
  logic [31:0] data_n;
  logic [4:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  assign trig = start || mode_s2 != mode_s3 || (INIT_CFG && rst_d && !reset);
  assign wr_done = cfg_write && !cfg_waitrequest;
  assign tbl_end = tbl_addr == 6'h3F || idx == 5'(WRITES);
  assign tbl_mode = seq_mode;
  assign tbl_idx = idx[3:0];
  assign busy = state != IDLE;
  // Synchronisers; stage 3 tracks stage 2 even in reset so no change is seen on release
  always_ff @(posedge clk_sys) begin
    mode_s1 <= mode;
    mode_s2 <= mode_s1;
    mode_s3 <= mode_s2;
    lock_s1 <= pll_locked;
    lock_s2 <= lock_s1;
    rst_d <= reset;
  end
  // State and registered bus/status outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      seq_mode <= '0;
      cur_mode <= '0;
      pending <= 1'b0;
      core_reset <= 1'b0;
      lock_err <= 1'b0;
      cfg_write <= 1'b0;
      cfg_address <= '0;
      cfg_data <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      seq_mode <= seq_mode_n;
      cur_mode <= cur_mode_n;
      pending <= pending_n;
      core_reset <= core_reset_n;
      lock_err <= lock_err_n;
      cfg_write <= wr_n;
      cfg_address <= addr_n;
      cfg_data <= data_n;
      idx <= idx_n;
      cnt <= cnt_n;
    end
  end
  // Next state; each write is launched on the edge entering its state, then drops for a gap cycle
  always_comb begin
    state_n = state;
    seq_mode_n = seq_mode;
    cur_mode_n = cur_mode;
    pending_n = pending || trig;
    core_reset_n = core_reset;
    lock_err_n = lock_err;
    wr_n = cfg_write;
    addr_n = cfg_address;
    data_n = cfg_data;
    idx_n = idx;
    cnt_n = cnt + CW'(1);
    go_pre = 1'b0;
    case (state)
      IDLE: begin
        pending_n = 1'b0;
        go_pre = trig;
      end
      PRE, TBL: begin
        if (wr_done) begin
          wr_n = 1'b0;
          idx_n = idx + 5'(state == TBL);
        end else if (!cfg_write) begin
          state_n = tbl_end ? GO : TBL;
          wr_n = 1'b1;
          addr_n = tbl_end ? 6'd2 : tbl_addr;
          data_n = tbl_end ? 32'd0 : tbl_data;
        end
      end
      GO: begin
        if (wr_done) wr_n = 1'b0;
        else if (!cfg_write) begin
          state_n = UNLOCK;
          cnt_n = '0;
        end
      end
      UNLOCK: begin
        if (!lock_s2 || cnt == CW'(15)) begin
          state_n = LOCK;
          cnt_n = '0;
        end
      end
      LOCK: begin
        if (lock_s2 || cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state_n = DONE;
          core_reset_n = 1'b0;
          cur_mode_n = lock_s2 ? seq_mode : cur_mode;
          lock_err_n = !lock_s2;
        end
      end
      DONE: begin
        state_n = IDLE;
        pending_n = 1'b0;
        go_pre = pending || trig;
      end
      default: state_n = IDLE;
    endcase
    if (go_pre) begin
      state_n = PRE;
      seq_mode_n = mode_s2;
      core_reset_n = 1'b1;
      lock_err_n = 1'b0;
      wr_n = 1'b1;
      addr_n = '0;
      data_n = '0;
      idx_n = '0;
    end
  end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: directed vector bench for pll_reconfig_seq with bus, table and PLL models
module tb_pll_reconfig_seq;
  localparam int LT = 40;
  logic clk_sys = 0;
  logic reset = 1;
  logic start = 0;
  logic cfg_waitrequest = 0;
  logic pll_locked = 1;
  logic [1:0] mode = 0;
  logic [1:0] tbl_mode, cur_mode;
  logic [3:0] tbl_idx;
  logic [5:0] tbl_addr, cfg_address;
  logic [31:0] tbl_data, cfg_data;
  logic cfg_write, core_reset, busy, lock_err;
  int errors = 0, checks = 0;
  int end_at = 4;
  int cyc = 0, wr_num = 0, stall_at = -1, stall_left = 0, run = 0, pll_cnt = 0;
  int busy_falls = 0, lock_rise = 0, core_fall = 0;
  bit hold_low = 0, no_drop = 0, p_wr = 0, p_wq = 0, p_busy = 0, p_core = 0;
  logic [5:0] p_a = 0;
  logic [31:0] p_d = 0;
  logic [37:0] log_q[$];
  int log_cyc[$], log_hi[$];

  always #10 clk_sys = ~clk_sys;

  pll_reconfig_seq #(.MODES(3), .WRITES(4), .LOCK_TIMEOUT(LT), .INIT_CFG(1)) dut (
    .clk_sys(clk_sys), .reset(reset), .mode(mode), .start(start),
    .tbl_mode(tbl_mode), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cfg_waitrequest(cfg_waitrequest), .cfg_write(cfg_write), .cfg_address(cfg_address),
    .cfg_data(cfg_data), .pll_locked(pll_locked), .core_reset(core_reset), .busy(busy),
    .cur_mode(cur_mode), .lock_err(lock_err)
  );

  function automatic logic [5:0] ta(input logic [1:0] m, input int i);
    return 6'(16 + 4 * int'(m) + i);
  endfunction
  function automatic logic [31:0] td(input logic [1:0] m, input int i);
    return 32'hA500_0000 | (32'(m) << 8) | 32'(i);
  endfunction
  function automatic logic [37:0] ew(input logic [1:0] m, input int k, input int i);
    if (i == 0) return 38'h0;
    if (i == k + 1) return {6'd2, 32'h0};
    return {ta(m, i - 1), td(m, i - 1)};
  endfunction

  assign tbl_addr = (int'(tbl_idx) >= end_at) ? 6'h3F : ta(tbl_mode, int'(tbl_idx));
  assign tbl_data = td(tbl_mode, int'(tbl_idx));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output int n);
    n = 0;
    while (busy !== lvl && n < lim) begin
      @(negedge clk_sys);
      n++;
    end
    chk("busy_wait", busy, lvl);
  endtask

  // Bus slave, write logger, protocol checker and PLL model; decisions hold until the next rising edge
  always @(negedge clk_sys) begin
    cyc++;
    if (!reset) begin
      if (p_wr && p_wq) begin
        chk("hold_wr", cfg_write, 1);
        chk("hold_addr", cfg_address, p_a);
        chk("hold_data", cfg_data, p_d);
      end
      if (p_wr && !p_wq) chk("gap_after_wr", cfg_write, 0);
    end
    if (!busy) wr_num = 0;
    if (p_busy && !busy) busy_falls++;
    if (p_core && !core_reset) core_fall = cyc;
    p_busy = busy;
    p_core = core_reset;
    run = cfg_write ? run + 1 : 0;
    p_wr = cfg_write;
    p_a = cfg_address;
    p_d = cfg_data;
    cfg_waitrequest = cfg_write && wr_num == stall_at && stall_left > 0;
    if (cfg_waitrequest) stall_left--;
    p_wq = cfg_waitrequest;
    if (pll_cnt > 0) begin
      pll_cnt++;
      if (pll_cnt == 3 && !no_drop) pll_locked = 0;
      if (pll_cnt == 12) begin
        pll_cnt = 0;
        if (!hold_low) begin
          if (!pll_locked) lock_rise = cyc;
          pll_locked = 1;
        end
      end
    end
    if (cfg_write && !cfg_waitrequest && !reset) begin
      log_q.push_back({cfg_address, cfg_data});
      log_cyc.push_back(cyc);
      log_hi.push_back(run);
      chk("core_rst_during_wr", core_reset, 1);
      wr_num++;
      if (cfg_address == 6'd2) pll_cnt = 1;
    end
  end

  typedef struct {
    bit use_start;
    logic [1:0] md;
    int st_at;
    int st_len;
    int end_n;
    bit hold;
    bit nodrop;
    logic [1:0] exp_cur;
    bit exp_err;
  } vec_t;

  initial begin
    vec_t v[7];
    int n, k, bf;
    v[0] = '{1'b0, 2'd1, -1, 0, 4, 1'b0, 1'b0, 2'd1, 1'b0};
    v[1] = '{1'b1, 2'd1, 2, 5, 4, 1'b0, 1'b0, 2'd1, 1'b0};
    v[2] = '{1'b0, 2'd2, -1, 0, 1, 1'b0, 1'b0, 2'd2, 1'b0};
    v[3] = '{1'b0, 2'd0, -1, 0, 0, 1'b0, 1'b1, 2'd0, 1'b0};
    v[4] = '{1'b0, 2'd1, -1, 0, 4, 1'b1, 1'b0, 2'd0, 1'b1};
    v[5] = '{1'b1, 2'd1, 1, 2, 3, 1'b0, 1'b0, 2'd1, 1'b0};
    v[6] = '{1'b0, 2'd0, -1, 0, 4, 1'b0, 1'b0, 2'd0, 1'b0};
    repeat (3) @(negedge clk_sys);
    chk("rst_cfg_write", cfg_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_reset", core_reset, 0);
    chk("rst_lock_err", lock_err, 0);
    reset = 0;
    @(negedge clk_sys);
    chk("init_busy", busy, 1);
    chk("init_wr", cfg_write, 1);
    wait_busy(0, 400, n);
    chk("init_cur", cur_mode, 0);
    foreach (v[j]) begin
      k = v[j].end_n < 4 ? v[j].end_n : 4;
      end_at = v[j].end_n;
      hold_low = v[j].hold;
      no_drop = v[j].nodrop;
      stall_at = v[j].st_at;
      stall_left = v[j].st_len;
      log_q.delete();
      log_cyc.delete();
      log_hi.delete();
      if (v[j].use_start) begin
        start = 1;
        @(negedge clk_sys);
        start = 0;
        wait_busy(1, 10, n);
        n++;
      end else begin
        mode = v[j].md;
        wait_busy(1, 10, n);
      end
      chk($sformatf("v%0d_trig_lat", j), n, v[j].use_start ? 1 : 3);
      chk($sformatf("v%0d_pre_core_rst", j), core_reset, 1);
      chk($sformatf("v%0d_pre_wr0", j), {cfg_write, cfg_address}, {1'b1, 6'd0});
      chk($sformatf("v%0d_pre_err_clr", j), lock_err, 0);
      wait_busy(0, 400, n);
      @(negedge clk_sys);
      chk($sformatf("v%0d_n_writes", j), log_q.size(), k + 2);
      for (int i = 0; i < log_q.size() && i < k + 2; i++)
        chk($sformatf("v%0d_wr%0d", j, i), log_q[i], ew(v[j].md, k, i));
      if (log_q.size() == k + 2)
        chk($sformatf("v%0d_seq_span", j), log_cyc[k + 1] - log_cyc[0], 2 * (k + 1) + v[j].st_len);
      if (v[j].st_len > 0 && log_hi.size() > v[j].st_at)
        chk($sformatf("v%0d_stall_hold", j), log_hi[v[j].st_at], v[j].st_len + 1);
      chk($sformatf("v%0d_cur_mode", j), cur_mode, v[j].exp_cur);
      chk($sformatf("v%0d_lock_err", j), lock_err, v[j].exp_err);
      chk($sformatf("v%0d_core_reset", j), core_reset, 0);
      if (!v[j].hold && !v[j].nodrop)
        chk($sformatf("v%0d_core_fall", j), core_fall - lock_rise, 3);
    end
    end_at = 4;
    stall_at = -1;
    stall_left = 0;
    log_q.delete();
    log_cyc.delete();
    log_hi.delete();
    mode = 1;
    wait_busy(1, 10, n);
    n = 0;
    while (log_q.size() < 2 && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    chk("pend_reach_tbl", log_q.size(), 2);
    bf = busy_falls;
    mode = 2;
    wait_busy(0, 800, n);
    @(negedge clk_sys);
    chk("pend_n_writes", log_q.size(), 12);
    if (log_q.size() == 12) begin
      chk("pend_first_tbl", log_q[1], ew(2'd1, 4, 1));
      chk("pend_second_pre", log_q[6], ew(2'd2, 4, 0));
      chk("pend_second_tbl", log_q[7], ew(2'd2, 4, 1));
      chk("pend_second_go", log_q[11], ew(2'd2, 4, 5));
    end
    chk("pend_busy_falls", busy_falls - bf, 1);
    chk("pend_cur_mode", cur_mode, 2);
    stall_at = 2;
    stall_left = 20;
    start = 1;
    @(negedge clk_sys);
    start = 0;
    wait_busy(1, 10, n);
    n = 0;
    while (!(cfg_write && cfg_address == ta(2'd2, 1)) && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk("mid_stalled_addr", cfg_address, ta(2'd2, 1));
    repeat (2) @(negedge clk_sys);
    chk("mid_stalled_hold", cfg_write, 1);
    reset = 1;
    @(negedge clk_sys);
    stall_left = 0;
    chk("mid_rst_cfg_write", cfg_write, 0);
    chk("mid_rst_cfg_address", cfg_address, 0);
    chk("mid_rst_cfg_data", cfg_data, 0);
    chk("mid_rst_core_reset", core_reset, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lock_err", lock_err, 0);
    chk("mid_rst_cur_mode", cur_mode, 0);
    chk("mid_rst_tbl_idx", tbl_idx, 0);
    chk("mid_rst_tbl_mode", tbl_mode, 0);
    repeat (2) @(negedge clk_sys);
    reset = 0;
    @(negedge clk_sys);
    chk("rel_busy", busy, 1);
    chk("rel_wr", {cfg_write, cfg_address}, {1'b1, 6'd0});
    chk("rel_core_reset", core_reset, 1);
    wait_busy(0, 400, n);
    chk("rel_cur_mode", cur_mode, 2);
    chk("rel_lock_err", lock_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
